// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU control and the M-extension sequencer.
// Contents: ALU op codes, aluop encodings, funct7 patterns, M-extension funct3 codes
// and the multiply/divide FSM state type.
package alu_pkg;

  // ALU operation codes; ADD..XOR keep their legacy 3-bit values zero-extended.
  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_AND     = 4'b0010;
  localparam logic [3:0] ALU_OR      = 4'b0011;
  localparam logic [3:0] ALU_XOR     = 4'b0100;
  localparam logic [3:0] ALU_SLT     = 4'b0101;
  localparam logic [3:0] ALU_SLL     = 4'b0110;
  localparam logic [3:0] ALU_SRL     = 4'b0111;
  localparam logic [3:0] ALU_SRA     = 4'b1000;
  localparam logic [3:0] ALU_SLTU    = 4'b1001;
  localparam logic [3:0] ALU_INVALID = 4'b1111;

  // aluop encodings from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // funct7 patterns
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // M-extension funct3 codes
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// Iterative unsigned multiply / restoring divide datapath, one bit per cycle.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start_i       load init_hi_i/init_lo_i/opb_i and op_div_i
//   iterate_i     with start_i: run XLEN steps (0 = preloaded result, no steps)
//   abort_i       stop iterating (flush)
//   op_div_i      1 = divide, 0 = multiply
//   init_hi_i/init_lo_i/opb_i  initial accumulator halves and fixed operand
//   last_o        this cycle performs the final step
//   hi_o, lo_o    multiply: product {hi,lo}; divide: hi=remainder, lo=quotient
module md_iter_core #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            iterate_i,
  input  logic            abort_i,
  input  logic            op_div_i,
  input  logic [XLEN-1:0] init_hi_i,
  input  logic [XLEN-1:0] init_lo_i,
  input  logic [XLEN-1:0] opb_i,
  output logic            last_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [XLEN:0]    mul_sum, div_sh, div_diff;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
    div_d = div_q;
    // Multiply: add multiplicand when the multiplier LSB is set, then shift {carry,hi,lo} right.
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    // Divide: shift {rem,quo} left, try subtracting the divisor, keep it if non-negative.
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opb_q};
    if (start_i) begin
      hi_d  = init_hi_i;
      lo_d  = init_lo_i;
      opb_d = opb_i;
      div_d = op_div_i;
      cnt_d = iterate_i ? CNT_W'(XLEN) : '0;
    end else if (abort_i) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (div_q) begin
        if (!div_diff[XLEN]) begin
          hi_d = div_diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = div_sh[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_d = mul_sum[XLEN:1];
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_md_ctrl.sv
// Execute-stage ALU control: combinational RV32I op decode plus an iterative RV32M
// multiply/divide sequencer that stalls IF/ID/EX until its result is ready.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   valid_i, flush_i         EX holds a valid instruction / EX is flushed
//   aluop, funct3, funct7    decode inputs
//   rs1_val, rs2_val         operands
//   operation, md_sel        combinational ALU op code / M-extension select
//   stall_o                  pipeline hold
//   md_result, md_done       M result (held until the next completion) / one-cycle valid
// Build option: define MD_EARLY_OUT_EN to finish MUL with a zero operand and DIV/REM with
// |dividend| < |divisor| in one cycle.
module alu_md_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OP_W  = 4,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [1:0]      aluop,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [OP_W-1:0] operation,
  output logic            md_sel,
  output logic            stall_o,
  output logic [XLEN-1:0] md_result,
  output logic            md_done
);

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  // ---------------- decoder ----------------
  logic [3:0] op_base, op_dec;

  always_comb begin
    unique case (funct3)
      3'b000: op_base = ALU_ADD;
      3'b001: op_base = ALU_SLL;
      3'b010: op_base = ALU_SLT;
      3'b011: op_base = ALU_SLTU;
      3'b100: op_base = ALU_XOR;
      3'b101: op_base = ALU_SRL;
      3'b110: op_base = ALU_OR;
      3'b111: op_base = ALU_AND;
    endcase
  end

  always_comb begin
    op_dec = ALU_INVALID;
    unique case (aluop)
      ALUOP_ADD: op_dec = ALU_ADD;
      ALUOP_SUB: op_dec = ALU_SUB;
      ALUOP_RTYPE: begin
        // M-extension funct7 matches neither pattern, so it decodes INVALID.
        if (funct7 == F7_BASE) begin
          op_dec = op_base;
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      op_dec = ALU_SUB;
          else if (funct3 == 3'b101) op_dec = ALU_SRA;
        end
      end
      ALUOP_ITYPE: begin
        // Outside the shifts, funct7 is immediate bits and is not checked.
        if (funct3 == 3'b000) begin
          op_dec = ALU_ADD;
        end else if (funct3 == 3'b001) begin
          if (funct7 == F7_BASE) op_dec = ALU_SLL;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_BASE)     op_dec = ALU_SRL;
          else if (funct7 == F7_ALT) op_dec = ALU_SRA;
        end else begin
          op_dec = op_base;
        end
      end
    endcase
  end

  assign md_sel    = (aluop == ALUOP_RTYPE) && (funct7 == F7_MULDIV);
  assign operation = OP_W'(op_dec);

  // ---------------- operand preparation ----------------
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic            div_zero, div_ovf, early, fast, md_req;
  logic [XLEN-1:0] a_mag, b_mag, init_hi, init_lo, init_b;

  always_comb begin
    is_div   = funct3[2];
    a_sgn    = (funct3 == MD_MUL) || (funct3 == MD_MULH) || (funct3 == MD_MULHSU) ||
               (funct3 == MD_DIV) || (funct3 == MD_REM);
    b_sgn    = (funct3 == MD_MUL) || (funct3 == MD_MULH) ||
               (funct3 == MD_DIV) || (funct3 == MD_REM);
    a_neg    = a_sgn && rs1_val[XLEN-1];
    b_neg    = b_sgn && rs2_val[XLEN-1];
    a_mag    = a_neg ? -rs1_val : rs1_val;
    b_mag    = b_neg ? -rs2_val : rs2_val;
    div_zero = is_div && (rs2_val == '0);
    div_ovf  = ((funct3 == MD_DIV) || (funct3 == MD_REM)) &&
               (rs1_val == MinNeg) && (rs2_val == '1);
`ifdef MD_EARLY_OUT_EN
    early    = is_div ? (a_mag < b_mag) : ((rs1_val == '0) || (rs2_val == '0));
`else
    early    = 1'b0;
`endif
    fast     = div_zero || div_ovf || early;
    // Fast path preloads the final {remainder, quotient} / product and skips sign correction.
    if (fast) begin
      init_hi = (is_div && !div_ovf) ? rs1_val : '0;
      init_lo = div_zero ? '1 : (div_ovf ? rs1_val : '0);
      init_b  = '0;
    end else if (is_div) begin
      init_hi = '0;
      init_lo = a_mag;
      init_b  = b_mag;
    end else begin
      init_hi = '0;
      init_lo = b_mag;
      init_b  = a_mag;
    end
  end

  assign md_req = valid_i && md_sel && !flush_i;

  // ---------------- FSM ----------------
  md_state_e       state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d, rneg_q, rneg_d, bypass_q, bypass_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            core_start, core_abort, core_last;
  logic [XLEN-1:0] core_hi, core_lo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bypass_q <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      bypass_q <= bypass_d;
      res_q    <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (md_req) state_d = fast ? StDone : StBusy;
      StBusy: begin
        if (flush_i)        state_d = StIdle;
        else if (core_last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    core_start = 1'b0;
    core_abort = 1'b0;
    stall_o    = 1'b0;
    md_done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        core_start = md_req;
        stall_o    = md_req;
      end
      StBusy: begin
        core_abort = flush_i;
        stall_o    = !flush_i;
      end
      StDone: begin
        core_abort = flush_i;
        md_done    = !flush_i;
      end
      default: ;
    endcase
    if (!rst_n) begin
      core_start = 1'b0;
      stall_o    = 1'b0;
      md_done    = 1'b0;
    end
  end

  // Capture op and sign flags when a request is accepted.
  always_comb begin
    f3_d     = core_start ? funct3 : f3_q;
    neg_d    = core_start ? (a_neg ^ b_neg) : neg_q;
    rneg_d   = core_start ? a_neg : rneg_q;
    bypass_d = core_start ? fast : bypass_q;
  end

  md_iter_core #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (core_start),
    .iterate_i (!fast),
    .abort_i   (core_abort),
    .op_div_i  (is_div),
    .init_hi_i (init_hi),
    .init_lo_i (init_lo),
    .opb_i     (init_b),
    .last_o    (core_last),
    .hi_o      (core_hi),
    .lo_o      (core_lo)
  );

  // ---------------- sign correction / result select ----------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, res_sel;

  always_comb begin
    prod_fix = (neg_q && !bypass_q) ? -{core_hi, core_lo} : {core_hi, core_lo};
    quo_fix  = (neg_q && !bypass_q) ? -core_lo : core_lo;
    // Remainder follows the sign of the dividend.
    rem_fix  = (rneg_q && !bypass_q) ? -core_hi : core_hi;
    unique case (f3_q)
      MD_MUL:                        res_sel = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  res_sel = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               res_sel = quo_fix;
      default:                       res_sel = rem_fix;
    endcase
  end

  assign md_result = md_done ? res_sel : res_q;
  assign res_d     = md_result;

endmodule

// File: tb/tb_alu_md_ctrl.sv
module tb_alu_md_ctrl;
  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n, valid_i, flush_i;
  logic [1:0]      aluop;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [3:0]      operation;
  logic            md_sel, stall_o, md_done;
  logic [XLEN-1:0] md_result;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  alu_md_ctrl #(.XLEN(XLEN), .OP_W(4), .CNT_W($clog2(XLEN) + 1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_i),
    .flush_i   (flush_i),
    .aluop     (aluop),
    .funct3    (funct3),
    .funct7    (funct7),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .operation (operation),
    .md_sel    (md_sel),
    .stall_o   (stall_o),
    .md_result (md_result),
    .md_done   (md_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decode table: index by funct3.
  function automatic logic [3:0] exp_op(input int ao, input int f3, input int f7);
    logic [3:0] base [8];
    base = '{4'h0, 4'h6, 4'h5, 4'h9, 4'h4, 4'h7, 4'h3, 4'h2};
    if (ao == 0) return 4'h0;
    if (ao == 1) return 4'h1;
    if (ao == 2) begin
      if (f7 == 0) return base[f3];
      if (f7 == 32 && f3 == 0) return 4'h1;
      if (f7 == 32 && f3 == 5) return 4'h8;
      return 4'hF;
    end
    if (f3 == 0) return 4'h0;
    if (f3 == 1) return (f7 == 0) ? 4'h6 : 4'hF;
    if (f3 == 5) return (f7 == 0) ? 4'h7 : ((f7 == 32) ? 4'h8 : 4'hF);
    return base[f3];
  endfunction

  function automatic logic [31:0] md_model(input int f3, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      0: begin p = sa * sb; return p[31:0]; end
      1: begin p = sa * sb; return p[63:32]; end
      2: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
      3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from request to md_done.
  function automatic int lat_model(input int f3, input logic [31:0] a, input logic [31:0] b);
    bit fast;
    fast = (f3 >= 4) && (b == 0);
    fast |= (f3 == 4 || f3 == 6) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`ifdef MD_EARLY_OUT_EN
    if (f3 < 4) begin
      fast |= (a == 0) || (b == 0);
    end else begin
      longint ma, mb;
      ma = (f3 == 4 || f3 == 6) ? longint'($signed(a)) : longint'({32'h0, a});
      mb = (f3 == 4 || f3 == 6) ? longint'($signed(b)) : longint'({32'h0, b});
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      fast |= (ma < mb);
    end
`endif
    return fast ? 1 : XLEN + 1;
  endfunction

  task automatic present(input int f3, input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1;
    aluop   = 2'b10;
    funct7  = 7'b0000001;
    funct3  = 3'(f3);
    rs1_val = a;
    rs2_val = b;
  endtask

  task automatic md_op(input string tag, input int f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int lat;
    lat = lat_model(f3, a, b);
    @(negedge clk);
    present(f3, a, b);
    #1;
    chk({tag, "/req_stall"}, stall_o, 1);
    chk({tag, "/req_done"}, md_done, 0);
    chk({tag, "/held"}, md_result, last_res);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      valid_i = 1'b0;
      #1;
      chk({tag, "/stall"}, stall_o, (k < lat));
      chk({tag, "/done"}, md_done, (k == lat));
      if (k == lat) chk({tag, "/result"}, md_result, exp);
    end
    last_res = exp;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    aluop = '0; funct3 = '0; funct7 = '0; rs1_val = '0; rs2_val = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall", stall_o, 0);
    chk("reset_done", md_done, 0);
    chk("reset_result", md_result, 0);
    rst_n = 1'b1;

    // Decode sweep, no valid instruction presented.
    for (int ao = 0; ao < 4; ao++) begin
      for (int f3 = 0; f3 < 8; f3++) begin
        for (int f7 = 0; f7 < 128; f7++) begin
          aluop = 2'(ao); funct3 = 3'(f3); funct7 = 7'(f7);
          #1;
          chk($sformatf("dec_%0d_%0d_%0d", ao, f3, f7), operation, exp_op(ao, f3, f7));
          chk($sformatf("mdsel_%0d_%0d_%0d", ao, f3, f7), md_sel, (ao == 2 && f7 == 1));
        end
      end
    end
    chk("idle_stall", stall_o, 0);

    // Directed M operations.
    md_op("mul_7_m3", 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    md_op("mulhu_ff", 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    md_op("div_by0", 4, 32'd7, 32'd0, 32'hFFFF_FFFF);
    md_op("rem_by0", 6, 32'd7, 32'd0, 32'd7);
    md_op("div_ovf", 4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    md_op("rem_ovf", 6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    md_op("div_m7_2", 4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    md_op("rem_m7_2", 6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    md_op("divu_b2b_a", 5, 32'd100, 32'd7, 32'd14);
    md_op("divu_b2b_b", 5, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);
    md_op("mul_x0", 0, 32'h1234, 32'd0, 32'd0);

    // Flush at BUSY cycle 10.
    @(negedge clk);
    present(0, 32'd5, 32'd9);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
    flush_i = 1'b1;
    #1;
    chk("flush_stall", stall_o, 0);
    chk("flush_done", md_done, 0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      flush_i = 1'b0;
      #1;
      chk("post_flush_stall", stall_o, 0);
      chk("post_flush_done", md_done, 0);
    end
    chk("post_flush_result", md_result, last_res);

    // Reset in the middle of BUSY.
    @(negedge clk);
    present(5, 32'd1000, 32'd3);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_busy_stall", stall_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_busy_result", md_result, 0);
    last_res = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      chk("post_rst_stall", stall_o, 0);
      chk("post_rst_done", md_done, 0);
    end

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      int          f3;
      logic [31:0] a, b;
      f3 = $urandom_range(0, 7);
      a  = pick();
      b  = pick();
      md_op($sformatf("rand%0d_f3_%0d_%h_%h", i, f3, a, b), f3, a, b, md_model(f3, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
